pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. Each cycle it drives the write-enable and flush (bubble-insert) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, multi-cycle MUL/DIV occupancy of EX, instruction/data memory wait states, taken branches and exceptions under a fixed priority. It also keeps a frontend stall-cycle counter for performance monitoring.

## Interface
Parameters:
- MUL_CYCLES, default 4: cycles a multiply occupies EX (>=1)
- DIV_CYCLES, default 32: cycles a divide occupies EX (>=1)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- i_ID_rs, i_ID_rt  in  5 each  source register numbers of the instruction in ID
- i_ID_uses_rs, i_ID_uses_rt  in  1 each  ID instruction actually reads rs / rt
- i_EX_is_load  in  1  instruction in EX is a load
- i_EX_rd  in  5  destination register of the EX instruction
- i_ID_branch_taken  in  1  branch/jump in ID resolved taken
- i_ID_mdu_start  in  1  ID instruction is a MUL/DIV
- i_ID_mdu_is_div  in  1  qualifies i_ID_mdu_start: 1 = divide, 0 = multiply
- i_imem_ready  in  1  instruction fetch data valid this cycle
- i_dmem_ready  in  1  data memory access complete (1 when idle)
- i_exception  in  1  exception taken this cycle
- o_pc_we  out  1  PC write enable
- o_IF_ID_ena, o_ID_EX_ena, o_EX_MEM_ena, o_MEM_WB_ena  out  1 each  stage register enables
- o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush  out  1 each  load NOP/bubble into that register
- o_mdu_busy  out  1  MUL/DIV occupying EX
- o_stall_cycles  out  32  count of cycles with o_pc_we=0

## Operation
- Outputs are combinational from inputs and state. Every flush=1 is accompanied by the matching ena=1, and the register loads a bubble.
- State: mdu_cnt (width clog2(max(MUL_CYCLES,DIV_CYCLES))+1) and stall counter. o_mdu_busy = (mdu_cnt != 0).
- load_use = i_EX_is_load & (i_EX_rd != 0) & ((i_ID_uses_rs & i_ID_rs==i_EX_rd) | (i_ID_uses_rt & i_ID_rt==i_EX_rd)).
- Priority, first match wins. Any signal not listed is ena=1, flush=0.
  1. i_exception: pc_we=1; all flushes=1; mdu_cnt<=0 next edge.
  2. !i_dmem_ready: all enas=0, pc_we=0, flushes=0 (full freeze).
  3. mdu_busy: pc_we=0, IF_ID_ena=0, ID_EX_ena=0; EX_MEM_flush=1; MEM_WB_ena=1.
  4. load_use: pc_we=0, IF_ID_ena=0, ID_EX_flush=1.
  5. i_ID_branch_taken: pc_we=1, IF_ID_flush=1. An imem not-ready fetch in the same cycle is discarded.
  6. !i_imem_ready: pc_we=0, IF_ID_flush=1.
  7. normal: all ena=1, pc_we=1.
- MDU accept: in cases 5–7 with i_ID_mdu_start=1, mdu_cnt <= (i_ID_mdu_is_div ? DIV_CYCLES : MUL_CYCLES) - 1. A count of 1 therefore causes no stall.
- mdu_cnt != 0 decrements every edge, including case 2 (the MDU runs independently of the memory freeze). Only exception or reset clears it early.
- o_stall_cycles increments on every edge where o_pc_we=0. It wraps modulo 2^32.

## Timing
- Reset (synchronous, edge with reset=1): mdu_cnt=0, o_stall_cycles=0. After that edge, with inputs idle (ready=1, others 0): o_pc_we=1, all enas=1, all flushes=0, o_mdu_busy=0.
- Reset overrides an in-flight MDU count and any simultaneous exception.
- Load-use costs exactly 1 cycle. On the next cycle EX holds the bubble, so i_EX_is_load=0 and the stall clears.
- MDU op occupies EX for N cycles:
  - accept edge, then N-1 busy cycles, then advance on the cycle mdu_cnt=0;
  - the busy cycles are extended only by case-2 cycles that occur after mdu_cnt reaches 0.
- Branch penalty: 1 squashed IF slot, no delay slot.
- Zero-cycle combinational path from all inputs to enables/flushes.

## Test plan
- Reset, then idle inputs → pc_we=1, all enas=1, flushes=0, o_mdu_busy=0, o_stall_cycles=0.
- EX load rd=5, ID rs=5 uses_rs=1 → one cycle of pc_we=0, IF_ID_ena=0, ID_EX_flush=1, o_stall_cycles+1. Same with rd=0 → no stall.
- DIV accepted (DIV_CYCLES=32) → o_mdu_busy high 31 cycles with EX_MEM_flush=1, front frozen; o_stall_cycles +31. MUL with MUL_CYCLES=1 → no busy.
- i_dmem_ready=0 for 3 cycles at mdu_cnt=10 → all enas=0, pc_we=0; mdu_cnt=7 afterwards.
- i_exception at mdu_cnt=10 → pc_we=1, all flushes=1; o_mdu_busy=0 next cycle.
- i_ID_branch_taken=1 with i_imem_ready=0 → pc_we=1, IF_ID_flush=1. Load_use plus branch taken in the same cycle → load-use stall wins, pc_we=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush controller with MDU occupancy and stall counter
module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_ID_rs,
    input  logic [4:0]  i_ID_rt,
    input  logic        i_ID_uses_rs,
    input  logic        i_ID_uses_rt,
    input  logic        i_EX_is_load,
    input  logic [4:0]  i_EX_rd,
    input  logic        i_ID_branch_taken,
    input  logic        i_ID_mdu_start,
    input  logic        i_ID_mdu_is_div,
    input  logic        i_imem_ready,
    input  logic        i_dmem_ready,
    input  logic        i_exception,
    output logic        o_pc_we,
    output logic        o_IF_ID_ena,
    output logic        o_ID_EX_ena,
    output logic        o_EX_MEM_ena,
    output logic        o_MEM_WB_ena,
    output logic        o_IF_ID_flush,
    output logic        o_ID_EX_flush,
    output logic        o_EX_MEM_flush,
    output logic        o_mdu_busy,
    output logic [31:0] o_stall_cycles
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    logic [CW-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [31:0]   stall_q, stall_d;
    logic          load_use;
    logic          mdu_accept;

    assign load_use = i_EX_is_load && (i_EX_rd != 5'd0) &&
                      ((i_ID_uses_rs && (i_ID_rs == i_EX_rd)) ||
                       (i_ID_uses_rt && (i_ID_rt == i_EX_rd)));

    assign o_mdu_busy     = (mdu_cnt_q != '0);
    assign o_stall_cycles = stall_q;

    always_comb begin
        o_pc_we        = 1'b1;
        o_IF_ID_ena    = 1'b1;
        o_ID_EX_ena    = 1'b1;
        o_EX_MEM_ena   = 1'b1;
        o_MEM_WB_ena   = 1'b1;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_flush  = 1'b0;
        o_EX_MEM_flush = 1'b0;
        mdu_accept     = 1'b0;
        if (i_exception) begin
            o_IF_ID_flush  = 1'b1;
            o_ID_EX_flush  = 1'b1;
            o_EX_MEM_flush = 1'b1;
        end else if (!i_dmem_ready) begin
            o_pc_we      = 1'b0;
            o_IF_ID_ena  = 1'b0;
            o_ID_EX_ena  = 1'b0;
            o_EX_MEM_ena = 1'b0;
            o_MEM_WB_ena = 1'b0;
        end else if (o_mdu_busy) begin
            // EX keeps working on the MDU op; downstream sees bubbles
            o_pc_we        = 1'b0;
            o_IF_ID_ena    = 1'b0;
            o_ID_EX_ena    = 1'b0;
            o_EX_MEM_flush = 1'b1;
        end else if (load_use) begin
            o_pc_we       = 1'b0;
            o_IF_ID_ena   = 1'b0;
            o_ID_EX_flush = 1'b1;
        end else begin
            mdu_accept = i_ID_mdu_start;
            if (i_ID_branch_taken) begin
                o_IF_ID_flush = 1'b1;
            end else if (!i_imem_ready) begin
                o_pc_we       = 1'b0;
                o_IF_ID_flush = 1'b1;
            end
        end
    end

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (i_exception) begin
            mdu_cnt_d = '0;
        end else if (mdu_accept) begin
            mdu_cnt_d = i_ID_mdu_is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - 1'b1;
        end
        stall_d = stall_q + {31'd0, ~o_pc_we};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_cnt_q <= '0;
            stall_q   <= '0;
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
            stall_q   <= stall_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic       ex_load;
        logic [4:0] ex_rd;
        logic       br;
        logic       mdu_start;
        logic       is_div;
        logic       imem;
        logic       dmem;
        logic       exc;
    } vin_t;

    typedef struct {
        string      name;
        vin_t       in;
        logic [8:0] exp;
    } vec_t;

    // {pc_we, IF_ID_ena, ID_EX_ena, EX_MEM_ena, MEM_WB_ena, IF_ID_flush, ID_EX_flush, EX_MEM_flush, busy}
    localparam logic [8:0] P_NORM = 9'b111110000;
    localparam logic [8:0] P_LU   = 9'b001110100;
    localparam logic [8:0] P_BR   = 9'b111111000;
    localparam logic [8:0] P_IMEM = 9'b011111000;
    localparam logic [8:0] P_FRZ  = 9'b000000000;
    localparam logic [8:0] P_EXC  = 9'b111111110;
    localparam logic [8:0] P_BUSY = 9'b000110011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] i_ID_rs, i_ID_rt, i_EX_rd;
    logic i_ID_uses_rs, i_ID_uses_rt, i_EX_is_load, i_ID_branch_taken;
    logic i_ID_mdu_start, i_ID_mdu_is_div, i_imem_ready, i_dmem_ready, i_exception;
    logic o_pc_we, o_IF_ID_ena, o_ID_EX_ena, o_EX_MEM_ena, o_MEM_WB_ena;
    logic o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush, o_mdu_busy;
    logic [31:0] o_stall_cycles;
    logic m1_pc_we, m1_IF_ID_ena, m1_ID_EX_ena, m1_EX_MEM_ena, m1_MEM_WB_ena;
    logic m1_IF_ID_flush, m1_ID_EX_flush, m1_EX_MEM_flush, m1_mdu_busy;
    logic [31:0] m1_stall_cycles;

    int vectors = 0;
    int miscompares = 0;
    int m_cnt = 0;
    int unsigned m_stall = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .reset(reset),
        .i_ID_rs(i_ID_rs), .i_ID_rt(i_ID_rt),
        .i_ID_uses_rs(i_ID_uses_rs), .i_ID_uses_rt(i_ID_uses_rt),
        .i_EX_is_load(i_EX_is_load), .i_EX_rd(i_EX_rd),
        .i_ID_branch_taken(i_ID_branch_taken),
        .i_ID_mdu_start(i_ID_mdu_start), .i_ID_mdu_is_div(i_ID_mdu_is_div),
        .i_imem_ready(i_imem_ready), .i_dmem_ready(i_dmem_ready),
        .i_exception(i_exception),
        .o_pc_we(o_pc_we), .o_IF_ID_ena(o_IF_ID_ena), .o_ID_EX_ena(o_ID_EX_ena),
        .o_EX_MEM_ena(o_EX_MEM_ena), .o_MEM_WB_ena(o_MEM_WB_ena),
        .o_IF_ID_flush(o_IF_ID_flush), .o_ID_EX_flush(o_ID_EX_flush),
        .o_EX_MEM_flush(o_EX_MEM_flush), .o_mdu_busy(o_mdu_busy),
        .o_stall_cycles(o_stall_cycles)
    );

    pipeline_hazard_ctrl #(.MUL_CYCLES(1), .DIV_CYCLES(32)) dut_m1 (
        .clk(clk), .reset(reset),
        .i_ID_rs(i_ID_rs), .i_ID_rt(i_ID_rt),
        .i_ID_uses_rs(i_ID_uses_rs), .i_ID_uses_rt(i_ID_uses_rt),
        .i_EX_is_load(i_EX_is_load), .i_EX_rd(i_EX_rd),
        .i_ID_branch_taken(i_ID_branch_taken),
        .i_ID_mdu_start(i_ID_mdu_start), .i_ID_mdu_is_div(i_ID_mdu_is_div),
        .i_imem_ready(i_imem_ready), .i_dmem_ready(i_dmem_ready),
        .i_exception(i_exception),
        .o_pc_we(m1_pc_we), .o_IF_ID_ena(m1_IF_ID_ena), .o_ID_EX_ena(m1_ID_EX_ena),
        .o_EX_MEM_ena(m1_EX_MEM_ena), .o_MEM_WB_ena(m1_MEM_WB_ena),
        .o_IF_ID_flush(m1_IF_ID_flush), .o_ID_EX_flush(m1_ID_EX_flush),
        .o_EX_MEM_flush(m1_EX_MEM_flush), .o_mdu_busy(m1_mdu_busy),
        .o_stall_cycles(m1_stall_cycles)
    );

    function automatic vin_t idle();
        vin_t v;
        v = '0;
        v.imem = 1'b1;
        v.dmem = 1'b1;
        return v;
    endfunction

    function automatic logic is_load_use(vin_t v);
        return v.ex_load && (v.ex_rd != 0) &&
               ((v.uses_rs && v.rs == v.ex_rd) || (v.uses_rt && v.rt == v.ex_rd));
    endfunction

    // Reference: ordered hazard rules, MDU modelled as remaining busy cycles
    function automatic logic [8:0] model_out(vin_t v, int cnt);
        logic [8:0] r;
        if (v.exc)                  r = P_EXC;
        else if (!v.dmem)           r = P_FRZ;
        else if (cnt > 0)           r = P_BUSY;
        else if (is_load_use(v))    r = P_LU;
        else if (v.br)              r = P_BR;
        else if (!v.imem)           r = P_IMEM;
        else                        r = P_NORM;
        r[0] = (cnt > 0);
        return r;
    endfunction

    task automatic apply(vin_t v);
        i_ID_rs = v.rs; i_ID_rt = v.rt;
        i_ID_uses_rs = v.uses_rs; i_ID_uses_rt = v.uses_rt;
        i_EX_is_load = v.ex_load; i_EX_rd = v.ex_rd;
        i_ID_branch_taken = v.br; i_ID_mdu_start = v.mdu_start;
        i_ID_mdu_is_div = v.is_div; i_imem_ready = v.imem;
        i_dmem_ready = v.dmem; i_exception = v.exc;
    endtask

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic run_cycle(vin_t v, string nm, logic [8:0] exp);
        logic [8:0] got;
        logic [8:0] mexp;
        apply(v);
        #1;
        got = {o_pc_we, o_IF_ID_ena, o_ID_EX_ena, o_EX_MEM_ena, o_MEM_WB_ena,
               o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush, o_mdu_busy};
        mexp = model_out(v, m_cnt);
        check(nm, {23'd0, got}, {23'd0, exp});
        check({nm, "_stall"}, o_stall_cycles, m_stall);
        @(posedge clk);
        if (reset) begin
            m_cnt = 0;
            m_stall = 0;
        end else begin
            if (!mexp[8]) m_stall++;
            if (v.exc) m_cnt = 0;
            else if (v.dmem && m_cnt == 0 && !is_load_use(v) && v.mdu_start)
                m_cnt = (v.is_div ? 32 : 4) - 1;
            else if (m_cnt > 0) m_cnt--;
        end
        @(negedge clk);
    endtask

    task automatic run_model(vin_t v, string nm);
        run_cycle(v, nm, model_out(v, m_cnt));
    endtask

    vec_t tbl[12];

    initial begin
        vin_t v;
        int n;
        int unsigned s0;

        apply(idle());
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_cnt = 0;
        m_stall = 0;

        v = idle(); tbl[0] = '{"idle", v, P_NORM};
        v = idle(); v.ex_load = 1; v.ex_rd = 5; v.rs = 5; v.uses_rs = 1; tbl[1] = '{"lu_rs", v, P_LU};
        v = idle(); v.ex_load = 1; v.ex_rd = 7; v.rt = 7; v.uses_rt = 1; tbl[2] = '{"lu_rt", v, P_LU};
        v = idle(); v.ex_load = 1; v.ex_rd = 0; v.rs = 0; v.uses_rs = 1; tbl[3] = '{"lu_rd0", v, P_NORM};
        v = idle(); v.ex_load = 1; v.ex_rd = 5; v.rs = 5; v.uses_rs = 0; tbl[4] = '{"lu_unused", v, P_NORM};
        v = idle(); v.br = 1; tbl[5] = '{"branch", v, P_BR};
        v = idle(); v.br = 1; v.imem = 0; tbl[6] = '{"branch_imem", v, P_BR};
        v = idle(); v.imem = 0; tbl[7] = '{"imem_wait", v, P_IMEM};
        v = idle(); v.dmem = 0; v.br = 1; tbl[8] = '{"dmem_freeze", v, P_FRZ};
        v = idle(); v.exc = 1; tbl[9] = '{"exception", v, P_EXC};
        v = idle(); v.exc = 1; v.dmem = 0; tbl[10] = '{"exc_over_dmem", v, P_EXC};
        v = idle(); v.ex_load = 1; v.ex_rd = 9; v.rs = 9; v.uses_rs = 1; v.br = 1; tbl[11] = '{"lu_over_br", v, P_LU};

        run_cycle(idle(), "reset_idle", P_NORM);
        foreach (tbl[i]) run_cycle(tbl[i].in, tbl[i].name, tbl[i].exp);

        // DIV: 31 busy cycles, 31 stall cycles
        s0 = o_stall_cycles;
        v = idle(); v.mdu_start = 1; v.is_div = 1;
        run_cycle(v, "div_accept", P_NORM);
        n = 0;
        for (int i = 0; i < 40 && o_mdu_busy; i++) begin
            run_cycle(idle(), "div_busy", P_BUSY);
            n++;
        end
        check("div_busy_len", n, 31);
        check("div_stall_delta", o_stall_cycles - s0, 31);
        run_cycle(idle(), "div_done", P_NORM);

        // MUL with MUL_CYCLES=1 never busy
        v = idle(); v.mdu_start = 1;
        run_model(v, "mul_accept");
        check("mul1_busy", {31'd0, m1_mdu_busy}, 0);
        check("mul1_pc_we", {31'd0, m1_pc_we}, 1);
        while (m_cnt > 0) run_model(idle(), "mul4_busy");

        // Memory freeze while MDU counts down 10 -> 7
        v = idle(); v.mdu_start = 1; v.is_div = 1;
        run_model(v, "div2_accept");
        repeat (21) run_model(idle(), "div2_busy");
        v = idle(); v.dmem = 0;
        repeat (3) run_cycle(v, "div2_freeze", P_FRZ | 9'b1);
        n = 0;
        for (int i = 0; i < 40 && o_mdu_busy; i++) begin
            run_model(idle(), "div2_tail");
            n++;
        end
        check("div2_remaining", n, 7);

        // Exception cancels MDU at count 10
        v = idle(); v.mdu_start = 1; v.is_div = 1;
        run_model(v, "div3_accept");
        repeat (21) run_model(idle(), "div3_busy");
        v = idle(); v.exc = 1;
        run_cycle(v, "div3_exc", P_EXC | 9'b1);
        check("div3_busy_after_exc", {31'd0, o_mdu_busy}, 0);

        // Reset beats in-flight MDU and simultaneous exception
        v = idle(); v.mdu_start = 1; v.is_div = 1;
        run_model(v, "div4_accept");
        repeat (5) run_model(idle(), "div4_busy");
        reset = 1'b1;
        v = idle(); v.exc = 1;
        run_model(v, "reset_exc");
        reset = 1'b0;
        check("reset_busy", {31'd0, o_mdu_busy}, 0);
        check("reset_stall", o_stall_cycles, 0);

        for (int i = 0; i < 3000; i++) begin
            v.rs = 5'($urandom_range(0, 3));
            v.rt = 5'($urandom_range(0, 3));
            v.uses_rs = 1'($urandom);
            v.uses_rt = 1'($urandom);
            v.ex_load = 1'($urandom);
            v.ex_rd = 5'($urandom_range(0, 3));
            v.br = ($urandom_range(0, 7) == 0);
            v.mdu_start = ($urandom_range(0, 7) == 0);
            v.is_div = ($urandom_range(0, 3) == 0);
            v.imem = ($urandom_range(0, 4) != 0);
            v.dmem = ($urandom_range(0, 5) != 0);
            v.exc = ($urandom_range(0, 47) == 0);
            run_model(v, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
